// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 matrix frame sequencer.
package ws2812_pkg;
  localparam int PIX_W  = 6;
  localparam int FRM_W  = 5;
  localparam int ADDR_W = PIX_W + FRM_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SEND,
    S_LATCH,
    S_HOLD
  } state_e;

  // WS2812 expects green first on the wire.
  function automatic logic [23:0] pack_grb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {g, r, b};
  endfunction
endpackage

// File: rtl/ws2812_latch_timer.sv
// Latch-gap counter: armed by start, held at zero while hold is high,
// pulses done combinationally on its last counted cycle.
module ws2812_latch_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hold,
  output logic done,
  output logic busy
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  always_comb begin
    done   = busy_q && !hold && (cnt_q == LAST);
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (hold) begin
        cnt_d = '0;
      end else if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Walks one stored frame pixel by pixel into the WS2812 transmitter, then
// enforces the latch gap and the frame period before moving to the next frame.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS   = 64,
  parameter int NUM_FRAMES   = 32,
  parameter int RESET_CYCLES = 1000,
  parameter int FRAME_CYCLES = 1200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              hold_frame,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        red_in,
  input  logic [7:0]        green_in,
  input  logic [7:0]        blue_in,
  output logic [23:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              tx_idle,
  output logic [PIX_W-1:0]  pixel_out,
  output logic [FRM_W-1:0]  frame_out,
  output logic              latching,
  output logic              frame_done,
  output logic              overrun
);
  localparam int PIX_SH = $clog2(NUM_PIXELS);
  localparam int TW     = $clog2(FRAME_CYCLES);
  localparam logic [TW-1:0]    T_LAST = TW'(FRAME_CYCLES - 1);
  localparam logic [PIX_W-1:0] P_LAST = PIX_W'(NUM_PIXELS - 1);
  localparam logic [FRM_W-1:0] F_LAST = FRM_W'(NUM_FRAMES - 1);

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic [FRM_W-1:0]   frame_q, frame_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [23:0]        tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               late_q, late_d;
  logic               latch_start, latch_done, latch_busy;

  ws2812_latch_timer #(.CYCLES(RESET_CYCLES)) u_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .start (latch_start),
    .hold  (!tx_idle),
    .done  (latch_done),
    .busy  (latch_busy)
  );

  always_comb begin
    state_d      = state_q;
    pixel_d      = pixel_q;
    frame_d      = frame_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_en_d  = 1'b0;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    latch_start  = 1'b0;
    timer_d      = (timer_q == T_LAST) ? timer_q : timer_q + 1'b1;
    // late_q means the timer already sat at its limit a cycle ago, i.e. the
    // frame is past its period rather than exactly on it.
    late_d       = (timer_q == T_LAST);

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_FETCH;
          mem_rd_en_d = 1'b1;
          timer_d     = '0;
          late_d      = 1'b0;
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        state_d    = S_SEND;
        tx_data_d  = pack_grb(red_in, green_in, blue_in);
        tx_valid_d = 1'b1;
      end
      S_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (pixel_q == P_LAST) begin
            pixel_d     = '0;
            state_d     = S_LATCH;
            latch_start = 1'b1;
          end else begin
            pixel_d     = pixel_q + 1'b1;
            state_d     = S_FETCH;
            mem_rd_en_d = 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (latch_done) begin
          state_d      = S_HOLD;
          frame_done_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (timer_q == T_LAST) begin
          if (late_q) overrun_d = 1'b1;
          if (!hold_frame) frame_d = (frame_q == F_LAST) ? '0 : frame_q + 1'b1;
          if (enable) begin
            state_d     = S_FETCH;
            mem_rd_en_d = 1'b1;
            timer_d     = '0;
            late_d      = 1'b0;
          end else begin
            state_d   = S_IDLE;
            tx_data_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (mem_rd_en_d) mem_addr_d = (ADDR_W'(frame_d) << PIX_SH) | ADDR_W'(pixel_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pixel_q      <= '0;
      frame_q      <= '0;
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timer_q      <= '0;
      late_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pixel_q      <= pixel_d;
      frame_q      <= frame_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_en_q  <= mem_rd_en_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      timer_q      <= timer_d;
      late_q       <= late_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign pixel_out  = pixel_q;
  assign frame_out  = frame_q;
  assign latching   = latch_busy;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Sequences one 8x8 WS2812B matrix frame at a time. For each pixel it reads RGB from the frame memory, packs it GRB into a 24-bit word and hands it to the bit-serial transmitter over a valid/ready handshake.
- After the last pixel it enforces the WS2812 latch gap, then holds until the frame period expires and advances to the next stored frame.
- Sits between the frame memory (11-bit address = frame*64 + pixel) and the shift-register transmitter that drives the data pin.

Parameters:
- NUM_PIXELS, 64, pixels per frame (power of 2).
- NUM_FRAMES, 32, frames stored in memory (power of 2); NUM_PIXELS*NUM_FRAMES = 2048.
- RESET_CYCLES, 1000, latch-gap length in clk cycles (>= 50 us at 12 MHz).
- FRAME_CYCLES, 1200000, minimum frame start-to-start period in clk cycles (10 fps at 12 MHz).

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allow new frames to start.
- hold_frame  in  1  replay the current frame index instead of advancing.
- mem_addr  out  11  frame memory address {frame, pixel}.
- mem_rd_en  out  1  memory read strobe; data is valid on the next cycle.
- red_in, green_in, blue_in  in  8 each  memory read data.
- tx_data  out  24  {green, red, blue} pixel word.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter can accept a word.
- tx_idle  in  1  transmitter has shifted out its last bit.
- pixel_out  out  6  current pixel index.
- frame_out  out  5  current frame index.
- latching  out  1  high while the latch gap is counted.
- frame_done  out  1  one-cycle pulse when the latch gap completes.
- overrun  out  1  sticky; set when a frame exceeds FRAME_CYCLES.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, pixel=0, frame=0, all counters 0. Reset mid-frame aborts immediately with no drain; the transmitter shares rst_n.
- States: IDLE, FETCH, CAPTURE, SEND, LATCH, HOLD.
- IDLE: when enable=1, go to FETCH and clear frame_timer to 0.
- FETCH (1 cycle): mem_rd_en=1, mem_addr={frame, pixel}; go to CAPTURE.
- CAPTURE (1 cycle): register tx_data <= {green_in, red_in, blue_in}; go to SEND.
- Latency: tx_valid rises 2 cycles after FETCH is entered.
- SEND: tx_valid=1 and tx_data stable until tx_valid&tx_ready. The handshake cycle is the last cycle of SEND.
  - On handshake with pixel<NUM_PIXELS-1: pixel++, go to FETCH.
  - On handshake with pixel=NUM_PIXELS-1: pixel<=0, go to LATCH.
  - tx_valid never drops without a handshake.
- LATCH: latching=1. latch_cnt holds at 0 while tx_idle=0, then increments each cycle.
  - When latch_cnt=RESET_CYCLES-1: frame_done pulses for 1 cycle, go to HOLD.
  - The gap is exactly RESET_CYCLES cycles measured from the first tx_idle=1 cycle.
- HOLD: wait until frame_timer >= FRAME_CYCLES-1.
  - On that cycle: frame <= hold_frame ? frame : frame+1 (wraps NUM_FRAMES-1 -> 0).
  - Next state is FETCH if enable=1, else IDLE.
  - frame_timer is cleared to 0 on entry to that FETCH.
  - If frame_timer is already past the limit on entry to HOLD, set overrun and leave after 1 cycle.
- frame_timer: free-running from FETCH of pixel 0 and saturates at FRAME_CYCLES-1.
- enable=0 mid-frame: the frame completes, including the latch gap and hold; WS2812 frames are never truncated.
- hold_frame is sampled only on the HOLD exit cycle.
- pixel_out and frame_out mirror the internal indices at all times.

Decomposition:
- Package ws2812_pkg holds:
  - the state enum;
  - PIX_W=6 and FRM_W=5 constants;
  - a pack_grb(r,g,b) function returning a 24-bit word.
- One sub-module: ws2812_latch_timer, a parameterised counter with start/hold input, done pulse and busy flag. It is used for the latch gap.

Test Plan (NUM_PIXELS=4, NUM_FRAMES=4, RESET_CYCLES=8, FRAME_CYCLES=64; memory model returns r=addr, g=addr+1, b=addr+2):
- Reset, enable=1, tx_ready=1 -> tx_valid rises 3 cycles after reset release. First word is 0x010002 at mem_addr 0. Words for addresses 0-3 follow, 3 cycles apart.
- tx_ready held 0 for 5 cycles during pixel 2 -> tx_valid stays 1, tx_data stays 0x030204 and pixel_out stays 2 until the handshake.
- tx_idle held 0 for 10 cycles after the last handshake -> latching=1 throughout. frame_done pulses exactly 8 cycles after tx_idle rises.
- Frame sequence with hold_frame=0 -> next frame starts exactly 64 cycles after the previous start. frame_out goes 0,1,2,3,0. Frame 1's first mem_addr is 4.
- hold_frame=1 -> frame_out stays 1 and addresses 4-7 repeat. enable=0 during SEND -> the frame finishes, latch gap and hold run, then IDLE with all tx outputs 0.
- FRAME_CYCLES=20 -> overrun set after frame 0, next frame starts 1 cycle after HOLD entry. rst_n pulsed low mid-SEND -> outputs 0 immediately, restart from pixel 0 frame 0.
